// File: rtl/nibble_pkg.sv
// nibble_pkg -- shared definitions for the Nibble CPU memory responder.
//
// Contents:
//   NIBBLE_W   : native data width (one nibble).
//   state_t    : responder FSM states {IDLE, WAIT, ACK}.
//   parity_of  : even-parity bit of a nibble. It is only referenced when
//                NIBBLE_PARITY_EN is defined.
package nibble_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Returns the bit that makes {parity, data} contain an even number of ones.
    function automatic logic parity_of(input logic [NIBBLE_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/nibble_ram.sv
// nibble_ram -- register-array nibble memory used by nibble_mem_responder.
//
// Build option: NIBBLE_PARITY_EN adds one even-parity bit per word. Parity is
// computed on write and checked on read, and the read result is the perr flag.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low clear of every word and of the read
//                 register
//   wr_en    in   write strobe: mem[addr] <= wdata
//   rd_en    in   read strobe: rdata <= mem[addr] (registered)
//   addr     in   word address, ADDR_W bits
//   wdata    in   write data, DATA_W bits
//   perr_clr in   (NIBBLE_PARITY_EN only) clears perr
//   perr     out  (NIBBLE_PARITY_EN only) registered parity mismatch of the
//                 last read
//   rdata    out  registered read data
module nibble_ram
    import nibble_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = NIBBLE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef NIBBLE_PARITY_EN
    input  logic              perr_clr,
    output logic              perr,
`endif
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef NIBBLE_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] wword;

`ifdef NIBBLE_PARITY_EN
    assign wword = {parity_of(wdata), wdata};
`else
    assign wword = wdata;
`endif

    // NOTE: this array is small enough to build from flops, so it can take the
    // asynchronous clear. A block RAM macro could not be reset this way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking assignment, so every reader sees the value
            // from before this edge no matter what order the blocks run in.
            mem[addr] <= wword;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr][DATA_W-1:0];
        end
    end

`ifdef NIBBLE_PARITY_EN
    // A stored word, parity bit included, XORs to zero when it is intact.
    // Words cleared by reset are all zero, and that is a valid word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr <= 1'b0;
        end else if (perr_clr) begin
            perr <= 1'b0;
        end else if (rd_en) begin
            perr <= ^mem[addr];
        end
    end
`endif

endmodule

// File: rtl/nibble_mem_responder.sv
// nibble_mem_responder -- memory-side responder for the Nibble CPU control
// unit. It answers four-phase req/ack read and write transactions and inserts
// WAIT_CYCLES wait states before it raises ack.
//
// Build option: NIBBLE_PARITY_EN enables per-word parity and the perr flag.
// When it is not defined, perr is tied to 0.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   req    in   four-phase transaction request
//   we     in   1 = write, 0 = read (sampled with req)
//   addr   in   word address, ADDR_W bits (sampled with req)
//   wdata  in   write data, DATA_W bits (sampled with req)
//   rdata  out  registered read data, valid while ack = 1
//   ack    out  registered acknowledge
//   busy   out  registered, high whenever the FSM is not in IDLE
//   perr   out  read parity error, valid while ack = 1
module nibble_mem_responder
    import nibble_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = NIBBLE_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              perr
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;

    logic accept;
    logic access;
    logic wr_en;
    logic rd_en;

    // accept: a request is taken this edge. access: the memory operation
    // happens this edge, on the same edge that raises ack.
    assign accept = (state == IDLE) && req;
    assign access = (state == WAIT) && (cnt == 4'd0);
    assign wr_en  = access && we_l;
    assign rd_en  = access && !we_l;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_l    <= we;
                        addr_l  <= addr;
                        wdata_l <= wdata;
                        cnt     <= WAIT_CNT;
                        state   <= WAIT;
                        busy    <= 1'b1;
                    end
                end
                WAIT: begin
                    // The transaction completes even if req has already
                    // dropped. ACK then releases after a single cycle.
                    if (cnt == 4'd0) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    if (!req) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    nibble_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addr_l),
        .wdata   (wdata_l),
`ifdef NIBBLE_PARITY_EN
        .perr_clr(accept),
        .perr    (perr),
`endif
        .rdata   (rdata)
    );

`ifndef NIBBLE_PARITY_EN
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_mem_responder.sv
// tb_nibble_mem_responder -- bench for nibble_mem_responder.
// dut0 is built with WAIT_CYCLES=0 and dut1 with WAIT_CYCLES=1. When a request
// is driven, the expected rdata goes into a queue. It is popped and compared
// when ack is seen. Inputs are driven and outputs sampled on the falling edge.
module tb_nibble_mem_responder;

    localparam int LIMIT = 20;

    typedef struct {
        logic [3:0] exp_rdata;
        bit         is_read;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       req     [2];
    logic       we      [2];
    logic [3:0] addr    [2];
    logic [3:0] wdata   [2];
    logic [3:0] rdata_o [2];
    logic       ack_o   [2];
    logic       busy_o  [2];
    logic       perr_o  [2];

    logic [3:0] mem_model [2][16];
    logic [3:0] last_rd   [2];
    exp_t       sb [$];

    int checks = 0;
    int errors = 0;

    nibble_mem_responder #(.ADDR_W(4), .DATA_W(4), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata_o[0]), .ack(ack_o[0]), .busy(busy_o[0]),
        .perr(perr_o[0])
    );

    nibble_mem_responder #(.ADDR_W(4), .DATA_W(4), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata_o[1]), .ack(ack_o[1]), .busy(busy_o[1]),
        .perr(perr_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_model();
        for (int w = 0; w < 2; w++) begin
            last_rd[w] = 4'h0;
            for (int a = 0; a < 16; a++) mem_model[w][a] = 4'h0;
        end
        sb.delete();
    endtask

    // Drive a request on DUT w and queue what rdata must show at ack.
    task automatic start_txn(input int w, input bit is_write,
                             input logic [3:0] a, input logic [3:0] d);
        exp_t e;
        req[w] = 1'b1; we[w] = is_write; addr[w] = a; wdata[w] = d;
        if (is_write) begin
            mem_model[w][a] = d;
            e.exp_rdata = last_rd[w];
            e.is_read = 1'b0;
        end else begin
            e.exp_rdata = mem_model[w][a];
            last_rd[w] = e.exp_rdata;
            e.is_read = 1'b1;
        end
        sb.push_back(e);
    endtask

    // Count falling edges until ack is seen, up to LIMIT.
    task automatic wait_ack(input int w, output int edges, output bit seen);
        edges = 0; seen = 1'b0;
        while (!seen && edges < LIMIT) begin
            @(negedge clk);
            edges++;
            if (ack_o[w] === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int edges; bit seen; exp_t e;
        reset = 1'b0;
        for (int w = 0; w < 2; w++) begin
            req[w] = 1'b0; we[w] = 1'b0; addr[w] = 4'h0; wdata[w] = 4'h0;
        end
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            checks++; if (ack_o[w] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b want 0", w, ack_o[w]); end
            checks++; if (busy_o[w] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", w, busy_o[w]); end
            checks++; if (rdata_o[w] !== 4'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", w, rdata_o[w]); end
            checks++; if (perr_o[w] !== 1'b0) begin errors++; $display("FAIL reset_perr[%0d]: got %b want 0", w, perr_o[w]); end
        end
        start_txn(1, 1'b0, 4'h7, 4'h0);
        wait_ack(1, edges, seen);
        e = sb.pop_front();
        checks++; if (edges != 3) begin errors++; $display("FAIL reset_read_latency: got %0d edges want 3", edges); end
        checks++; if (rdata_o[1] !== e.exp_rdata) begin errors++; $display("FAIL reset_read_rdata: got %h want %h", rdata_o[1], e.exp_rdata); end
        req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int edges; bit seen; exp_t e;
        start_txn(1, 1'b1, 4'h3, 4'hA);
        wait_ack(1, edges, seen);
        e = sb.pop_front();
        checks++; if (edges != 3) begin errors++; $display("FAIL wr_latency: got %0d edges want 3", edges); end
        checks++; if (rdata_o[1] !== e.exp_rdata) begin errors++; $display("FAIL wr_rdata_unchanged: got %h want %h", rdata_o[1], e.exp_rdata); end
        checks++; if (busy_o[1] !== 1'b1) begin errors++; $display("FAIL wr_busy_in_ack: got %b want 1", busy_o[1]); end
        req[1] = 1'b0;
        @(negedge clk);
        checks++; if (ack_o[1] !== 1'b0 || busy_o[1] !== 1'b0) begin errors++; $display("FAIL wr_release: ack=%b busy=%b want 0 0", ack_o[1], busy_o[1]); end

        start_txn(1, 1'b0, 4'h3, 4'h0);
        wait_ack(1, edges, seen);
        e = sb.pop_front();
        checks++; if (edges != 3) begin errors++; $display("FAIL rd_latency: got %0d edges want 3", edges); end
        checks++; if (rdata_o[1] !== e.exp_rdata) begin errors++; $display("FAIL rd_rdata: got %h want %h", rdata_o[1], e.exp_rdata); end
        checks++; if (perr_o[1] !== 1'b0) begin errors++; $display("FAIL rd_perr: got %b want 0", perr_o[1]); end
        req[1] = 1'b0;
        @(negedge clk);
        checks++; if (ack_o[1] !== 1'b0) begin errors++; $display("FAIL rd_release: ack=%b want 0", ack_o[1]); end
    endtask

    task automatic test_zero_wait();
        int edges; bit seen; exp_t e;
        start_txn(0, 1'b1, 4'hF, 4'h5);
        wait_ack(0, edges, seen);
        e = sb.pop_front();
        checks++; if (edges != 2) begin errors++; $display("FAIL zw_wr_latency: got %0d edges want 2", edges); end
        checks++; if (rdata_o[0] !== e.exp_rdata) begin errors++; $display("FAIL zw_wr_rdata: got %h want %h", rdata_o[0], e.exp_rdata); end
        req[0] = 1'b0;
        @(negedge clk);
        start_txn(0, 1'b0, 4'hF, 4'h0);
        wait_ack(0, edges, seen);
        e = sb.pop_front();
        checks++; if (edges != 2) begin errors++; $display("FAIL zw_rd_latency: got %0d edges want 2", edges); end
        checks++; if (rdata_o[0] !== e.exp_rdata) begin errors++; $display("FAIL zw_rd_rdata: got %h want %h", rdata_o[0], e.exp_rdata); end
        checks++; if (perr_o[0] !== 1'b0) begin errors++; $display("FAIL zw_rd_perr: got %b want 0", perr_o[0]); end
        req[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_operand_latch();
        int edges; bit seen; exp_t e;
        start_txn(1, 1'b0, 4'h3, 4'h0);
        @(negedge clk);
        // Change every operand while the request sits in WAIT.
        addr[1] = 4'h0; we[1] = 1'b1; wdata[1] = 4'hF;
        wait_ack(1, edges, seen);
        e = sb.pop_front();
        checks++; if (edges + 1 != 3) begin errors++; $display("FAIL latch_latency: got %0d edges want 3", edges + 1); end
        checks++; if (rdata_o[1] !== e.exp_rdata) begin errors++; $display("FAIL latch_rdata: got %h want %h", rdata_o[1], e.exp_rdata); end
        req[1] = 1'b0;
        @(negedge clk);
        // Address 0 must not have received the late write data.
        start_txn(1, 1'b0, 4'h0, 4'h0);
        wait_ack(1, edges, seen);
        e = sb.pop_front();
        checks++; if (rdata_o[1] !== e.exp_rdata) begin errors++; $display("FAIL latch_no_write: got %h want %h", rdata_o[1], e.exp_rdata); end
        req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        int edges; bit seen; int ack_cnt; exp_t e;
        start_txn(1, 1'b1, 4'h5, 4'h6);
        @(negedge clk);
        req[1] = 1'b0;
        ack_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_o[1] === 1'b1) ack_cnt++;
        end
        e = sb.pop_front();
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL drop_ack_cycles: got %0d want 1", ack_cnt); end
        checks++; if (busy_o[1] !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy_o[1]); end
        checks++; if (rdata_o[1] !== e.exp_rdata) begin errors++; $display("FAIL drop_rdata: got %h want %h", rdata_o[1], e.exp_rdata); end
        start_txn(1, 1'b0, 4'h5, 4'h0);
        wait_ack(1, edges, seen);
        e = sb.pop_front();
        checks++; if (rdata_o[1] !== e.exp_rdata) begin errors++; $display("FAIL drop_write_done: got %h want %h", rdata_o[1], e.exp_rdata); end
        checks++; if (perr_o[1] !== 1'b0) begin errors++; $display("FAIL drop_perr: got %b want 0", perr_o[1]); end
        req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_txn();
        int edges; bit seen; int ack_cnt; exp_t e;
        start_txn(1, 1'b1, 4'h2, 4'h9);
        @(negedge clk);
        // The FSM is in WAIT with one wait state left; the write has not happened yet.
        reset = 1'b0;
        req[1] = 1'b0;
        clear_model();
        @(negedge clk);
        checks++; if (ack_o[1] !== 1'b0 || busy_o[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: ack=%b busy=%b want 0 0", ack_o[1], busy_o[1]); end
        reset = 1'b1;
        ack_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_o[1] === 1'b1) ack_cnt++;
        end
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL rst_mid_ack: got %0d ack cycles want 0", ack_cnt); end
        start_txn(1, 1'b0, 4'h2, 4'h0);
        wait_ack(1, edges, seen);
        e = sb.pop_front();
        checks++; if (edges != 3) begin errors++; $display("FAIL rst_mid_latency: got %0d edges want 3", edges); end
        checks++; if (rdata_o[1] !== e.exp_rdata) begin errors++; $display("FAIL rst_mid_rdata: got %h want %h", rdata_o[1], e.exp_rdata); end
        checks++; if (perr_o[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_perr: got %b want 0", perr_o[1]); end
        req[1] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_operand_latch();
        test_early_drop();
        test_reset_mid_txn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
